comparador_serial_izq_der: RTL

- Sequential, bit-serial counterpart of the combinational left-to-right comparator network.
- Accepts one A/B operand pair through a valid/ready handshake.
- Scans the pair MSB-first at one bit per clock, using a 3-state comparison register.
- Presents Zout to the downstream consumer through a second valid/ready handshake.
- Zout = 1 when A <= B, Zout = 0 when A > B. This matches the combinational network, so both can be cross-checked in the same bench.

---
 rtl/comparador_serial_izq_der.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/comparador_serial_izq_der.sv
// -----------------------------------------------------------------------------
// comparador_serial_izq_der
//
// Purpose:
//    Bit-serial, MSB-first unsigned comparator. One A/B pair is taken through a
//    valid/ready handshake and scanned one bit per clock. A three-valued
//    comparison register (EQ / GT / LT) latches the first differing bit. The
//    result goes out through a second valid/ready handshake:
//       Zout = 1 when A <= B, Zeq = 1 when A == B.
//    Zout matches the combinational left-to-right comparator network, so the
//    two can be cross-checked against each other.
//
// Parameters:
//    N          operand width in bits (N >= 2)
//
// Ports:
//    clk        clock, every flop on the rising edge
//    reset      asynchronous, active-high reset
//    in_valid   operand pair on A/B is valid
//    in_ready   block can accept a pair (high only while idle)
//    A, B       unsigned operands, N bits each
//    out_valid  result valid (registered)
//    out_ready  consumer accepts the result
//    Zout       1 when A <= B (registered)
//    Zeq        1 when A == B (registered)
//
// Configuration macro:
//    COMPARADOR_SALIDA_TEMPRANA_EN
//       When defined, the scan ends at the first differing bit, so the latency
//       equals the 1-based MSB position of that bit. Equal operands still take
//       N cycles. When undefined, the latency is always N cycles.
// -----------------------------------------------------------------------------
module comparador_serial_izq_der #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         Zout,
   output logic         Zeq
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMP_EQ = 2'd0,
      CMP_GT = 2'd1,
      CMP_LT = 2'd2
   } cmp_t;

   // One comparison step: a decision that is already taken is kept; while
   // still equal, the current bit pair may decide it.
   function automatic cmp_t cmp_step(input cmp_t cur, input logic a_bit, input logic b_bit);
      cmp_t res;
      res = cur;
      case (cur)
         CMP_EQ: begin
            if (a_bit && !b_bit) begin
               res = CMP_GT;
            end else if (!a_bit && b_bit) begin
               res = CMP_LT;
            end else begin
               res = CMP_EQ;
            end
         end
         CMP_GT:  res = CMP_GT;
         CMP_LT:  res = CMP_LT;
         default: res = CMP_EQ;
      endcase
      return res;
   endfunction

   state_t         state_r;
   cmp_t           cmp_r;
   logic [N-1:0]   sha_r;
   logic [N-1:0]   shb_r;
   logic [CW-1:0]  cnt_r;

   cmp_t           next_cmp_s;
   logic           last_s;

   // Comparison value after the current MSB pair, and end-of-scan detection.
   always_comb begin
      next_cmp_s = cmp_step(cmp_r, sha_r[N-1], shb_r[N-1]);
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
      // Stop as soon as the comparison is decided, or on the last bit.
      last_s = (cnt_r == CNT_ONE) || (next_cmp_s != CMP_EQ);
`else
      last_s = (cnt_r == CNT_ONE);
`endif
   end

   // Input handshake is open only while idle.
   assign in_ready = (state_r == IDLE);

   // Control FSM, datapath and registered result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         cmp_r     <= CMP_EQ;
         sha_r     <= '0;
         shb_r     <= '0;
         cnt_r     <= CNT_ZERO;
         out_valid <= 1'b0;
         Zout      <= 1'b0;
         Zeq       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sha_r   <= A;
                  shb_r   <= B;
                  cnt_r   <= CNT_INIT;
                  cmp_r   <= CMP_EQ;
                  state_r <= SCAN;
               end else begin
                  state_r <= IDLE;
               end
            end

            SCAN: begin
               cmp_r <= next_cmp_s;
               sha_r <= {sha_r[N-2:0], 1'b0};
               shb_r <= {shb_r[N-2:0], 1'b0};
               cnt_r <= cnt_r - CNT_ONE;
               if (last_s) begin
                  // Result is loaded from the value that includes this bit.
                  Zout      <= (next_cmp_s != CMP_GT);
                  Zeq       <= (next_cmp_s == CMP_EQ);
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  state_r   <= SCAN;
               end
            end

            DONE: begin
               // Result held stable until the consumer takes it.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  state_r   <= DONE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               cmp_r     <= CMP_EQ;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
